inst_cache_assoc: RTL and testbench

Parametrised set-associative instruction cache between the fetch stage and the memory controller. It replaces the single-word direct-mapped cache with multi-word lines, 1 or 2 ways with LRU replacement, and an internal line-refill state machine that fetches a missed line from memory one word per handshake. It also supports a whole-cache flush for fence.i.

---
 rtl/inst_cache_assoc.sv | 185 ++++++++++++++++++
 tb/tb_inst_cache_assoc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_assoc.sv
// Set-associative instruction cache (1 or 2 ways, LRU) with a word-at-a-time
// line refill engine and a whole-cache flush for fence.i.
module inst_cache_assoc #(
    parameter int ADDR_WIDTH = 32,
    parameter int SET_BITS   = 6,
    parameter int LINE_BITS  = 2,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  flush_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  hit_o,
    output logic [31:0]           inst_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_data_i
);

    localparam int TAG_W  = ADDR_WIDTH - 2 - LINE_BITS - SET_BITS;
    localparam int SETS   = 1 << SET_BITS;
    localparam int WORDS  = 1 << LINE_BITS;
    localparam int OFF_LO = LINE_BITS + 2;
    localparam int LINE_W = ADDR_WIDTH - OFF_LO;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                       state_r;
    logic [LINE_BITS-1:0]         cnt_r;
    logic [LINE_W-1:0]            line_r;
    logic                         victim_r;
    logic [SETS-1:0][WAYS-1:0]    valid_r;
    logic [SETS-1:0]              lru_r;
    logic [TAG_W-1:0]             tag_r  [SETS][WAYS];
    logic [31:0]                  data_r [SETS][WAYS][WORDS];

    logic [LINE_BITS-1:0]         word_s;
    logic [SET_BITS-1:0]          index_s;
    logic [TAG_W-1:0]             tag_s;
    logic [SET_BITS-1:0]          fill_index_s;
    logic [TAG_W-1:0]             fill_tag_s;
    logic [WAYS-1:0]              way_hit_s;
    logic                         any_hit_s;
    logic                         hit_way_s;
    logic                         lookup_s;
    logic                         bypass_s;
    logic                         victim_s;
    logic                         last_s;
    logic                         unused_pc_bits_s;

    assign word_s           = pc_i[OFF_LO-1:2];
    assign index_s          = pc_i[SET_BITS+OFF_LO-1:OFF_LO];
    assign tag_s            = pc_i[ADDR_WIDTH-1:SET_BITS+OFF_LO];
    assign fill_index_s     = line_r[SET_BITS-1:0];
    assign fill_tag_s       = line_r[LINE_W-1:SET_BITS];
    assign last_s           = &cnt_r;
    assign unused_pc_bits_s = ^pc_i[1:0];

    assign lookup_s = req_i && rdy && !flush_i && (state_r == IDLE);
    assign bypass_s = (state_r == FILL) && mem_ack_i && req_i
                      && (pc_i[ADDR_WIDTH-1:OFF_LO] == line_r) && (word_s == cnt_r);

    // Per-way tag compare for the addressed set.
    always_comb begin
        way_hit_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit_s[w] = valid_r[index_s][w] && (tag_r[index_s][w] == tag_s);
        end
        any_hit_s = |way_hit_s;
        hit_way_s = (WAYS == 2) ? !way_hit_s[0] : 1'b0;
    end

    // Victim choice: first invalid way, otherwise the way the LRU bit names.
    always_comb begin
        victim_s = 1'b0;
        if (WAYS == 1) begin
            victim_s = 1'b0;
        end else if (!valid_r[index_s][0]) begin
            victim_s = 1'b0;
        end else if (!valid_r[index_s][WAYS-1]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[index_s];
        end
    end

    // Hit/instruction output; a matching refill word is forwarded straight from memory.
    always_comb begin
        hit_o  = 1'b0;
        inst_o = 32'd0;
        if (bypass_s) begin
            hit_o  = 1'b1;
            inst_o = mem_data_i;
        end else if (lookup_s && any_hit_s) begin
            hit_o  = 1'b1;
            inst_o = data_r[index_s][hit_way_s][word_s];
        end else begin
            hit_o  = 1'b0;
            inst_o = 32'd0;
        end
    end

    // Refill FSM, valid/LRU bookkeeping and memory request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            line_r     <= '0;
            victim_r   <= 1'b0;
            valid_r    <= '0;
            lru_r      <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            busy_o     <= 1'b0;
        end else if (flush_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            valid_r   <= '0;
            lru_r     <= '0;
            mem_req_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (lookup_s && any_hit_s) begin
                        if (WAYS == 2) begin
                            lru_r[index_s] <= !hit_way_s;
                        end
                    end else if (lookup_s) begin
                        // The victim is invalidated now so a half-written line never hits.
                        state_r                    <= FILL;
                        cnt_r                      <= '0;
                        line_r                     <= pc_i[ADDR_WIDTH-1:OFF_LO];
                        victim_r                   <= victim_s;
                        valid_r[index_s][victim_s] <= 1'b0;
                        mem_req_o                  <= 1'b1;
                        mem_addr_o                 <= {pc_i[ADDR_WIDTH-1:OFF_LO], {OFF_LO{1'b0}}};
                        busy_o                     <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        if (last_s) begin
                            valid_r[fill_index_s][victim_r] <= 1'b1;
                            if (WAYS == 2) begin
                                lru_r[fill_index_s] <= !victim_r;
                            end
                            state_r   <= IDLE;
                            cnt_r     <= '0;
                            mem_req_o <= 1'b0;
                            busy_o    <= 1'b0;
                        end else begin
                            cnt_r      <= cnt_r + LINE_BITS'(1);
                            mem_addr_o <= mem_addr_o + ADDR_WIDTH'(4);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    mem_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: refill words and the tag on the final word; never reset.
    always_ff @(posedge clk) begin
        if ((state_r == FILL) && mem_ack_i && !flush_i) begin
            data_r[fill_index_s][victim_r][cnt_r] <= mem_data_i;
            if (last_s) begin
                tag_r[fill_index_s][victim_r] <= fill_tag_s;
            end
        end
    end

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Directed bench for inst_cache_assoc: a recency-ordered line-residency model
// checked every cycle, plus literal expectations from the test plan.
module tb_inst_cache_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        flush_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        hit_o;
    logic [31:0] inst_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    inst_cache_assoc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flush_i   (flush_i),
        .req_i     (req_i),
        .pc_i      (pc_i),
        .hit_o     (hit_o),
        .inst_o    (inst_o),
        .busy_o    (busy_o),
        .mem_req_o (mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i (mem_ack_i),
        .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // Backing memory contents: line 0x1000 holds 0xA0..0xA3, every word distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + {30'd0, a[3:2]} + (((a - 32'h1000) >> 4) << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: resident lines (16-byte aligned) with last-use time; at most 2 per set.
    int          stamp [bit [31:0]];
    int          now_t = 0;
    bit          filling = 1'b0;
    bit [31:0]   fbase = 32'd0;
    int          fcnt = 0;
    bit [31:0]   key_v;
    bit [31:0]   line_v;
    bit [31:0]   oldest_v;
    int          oldest_t;
    int          in_set;
    bit          e_hit;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stamp.delete();
                filling = 1'b0;
                fcnt    = 0;
                chk("rst_hit", hit_o, 32'd0);
                chk("rst_inst", inst_o, 32'd0);
                chk("rst_req", mem_req_o, 32'd0);
                chk("rst_busy", busy_o, 32'd0);
                chk("rst_addr", mem_addr_o, 32'd0);
            end else begin
                line_v = {pc_i[31:4], 4'h0};
                e_hit  = (filling && mem_ack_i && req_i && line_v == fbase && int'(pc_i[3:2]) == fcnt)
                      || (!filling && req_i && rdy && !flush_i && stamp.exists(line_v));
                chk("m_hit", hit_o, {31'd0, e_hit});
                chk("m_inst", inst_o, e_hit ? mem_word({pc_i[31:2], 2'b00}) : 32'd0);
                chk("m_req", mem_req_o, {31'd0, filling});
                chk("m_busy", busy_o, {31'd0, filling});
                if (filling) chk("m_addr", mem_addr_o, fbase + 32'(4 * fcnt));
                now_t++;
                if (flush_i) begin
                    stamp.delete();
                    filling = 1'b0;
                    fcnt    = 0;
                end else if (filling) begin
                    if (mem_ack_i) begin
                        fcnt++;
                        if (fcnt == 4) begin
                            stamp[fbase] = now_t;
                            filling = 1'b0;
                            fcnt    = 0;
                        end
                    end
                end else if (req_i && rdy) begin
                    if (stamp.exists(line_v)) begin
                        stamp[line_v] = now_t;
                    end else begin
                        in_set   = 0;
                        oldest_t = 32'h7fffffff;
                        foreach (stamp[k]) begin
                            key_v = k;
                            if (key_v[9:4] == line_v[9:4]) begin
                                in_set++;
                                if (stamp[k] < oldest_t) begin
                                    oldest_t = stamp[k];
                                    oldest_v = key_v;
                                end
                            end
                        end
                        if (in_set >= 2) stamp.delete(oldest_v);
                        filling = 1'b1;
                        fbase   = line_v;
                        fcnt    = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [31:0] a, input logic exp_hit, input string name);
        req_i = 1'b1;
        pc_i  = a;
        #1;
        chk(name, hit_o, {31'd0, exp_hit});
        if (exp_hit) chk({name, "_inst"}, inst_o, mem_word(a));
        req_i = 1'b0;
        step();
    endtask

    task automatic touch(input logic [31:0] a);
        req_i = 1'b1;
        pc_i  = a;
        #1;
        chk("touch_hit", hit_o, 32'd1);
        step();
        req_i = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, input logic rdy_fill);
        req_i = 1'b1;
        rdy   = 1'b1;
        pc_i  = a;
        #1;
        chk("fill_miss", hit_o, 32'd0);
        step();
        rdy = rdy_fill;
        for (int k = 0; k < 4; k++) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_word(mem_addr_o);
            step();
        end
        mem_ack_i = 1'b0;
        req_i     = 1'b0;
        rdy       = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hit", hit_o, 32'd0);
        chk("reset_req", mem_req_o, 32'd0);
        chk("reset_busy", busy_o, 32'd0);
        rst_n = 1'b1;
        rdy   = 1'b1;

        // First request after reset misses and requests its line next cycle.
        req_i = 1'b1;
        pc_i  = 32'h1000;
        #1;
        chk("first_miss", hit_o, 32'd0);
        step();
        chk("first_req", mem_req_o, 32'd1);
        chk("first_addr", mem_addr_o, 32'h1000);
        req_i   = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Cold miss on 0x1008 with bypass on the third ack.
        req_i = 1'b1;
        pc_i  = 32'h1008;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("cold_addr", mem_addr_o, 32'h1000 + 32'(4 * k));
            mem_ack_i  = 1'b1;
            mem_data_i = 32'hA0 + 32'(k);
            if (k == 2) begin
                #1;
                chk("bypass_hit", hit_o, 32'd1);
                chk("bypass_inst", inst_o, 32'hA2);
            end
            step();
        end
        mem_ack_i = 1'b0;
        pc_i      = 32'h100C;
        #1;
        chk("after_fill_hit", hit_o, 32'd1);
        chk("after_fill_inst", inst_o, 32'hA3);
        step();
        req_i = 1'b0;

        // Two-way conflict in set 0.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        do_fill(32'h0000, 1'b1);
        do_fill(32'h0400, 1'b1);
        probe(32'h0000, 1'b1, "conf_a");
        probe(32'h0400, 1'b1, "conf_b");
        touch(32'h0000);
        do_fill(32'h0800, 1'b1);
        probe(32'h0000, 1'b1, "conf_keep");
        probe(32'h0800, 1'b1, "conf_new");
        probe(32'h0400, 1'b0, "conf_evicted");

        // Flush in the middle of a refill.
        do_fill(32'h2000, 1'b1);
        probe(32'h2000, 1'b1, "pre_flush");
        req_i = 1'b1;
        pc_i  = 32'h3000;
        step();
        for (int k = 0; k < 2; k++) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_word(mem_addr_o);
            step();
        end
        mem_ack_i = 1'b0;
        req_i     = 1'b0;
        flush_i   = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_req", mem_req_o, 32'd0);
        chk("flush_busy", busy_o, 32'd0);
        probe(32'h3000, 1'b0, "flush_partial");
        probe(32'h2000, 1'b0, "flush_old");

        // rdy low blocks hits and new misses, but not an ongoing refill.
        do_fill(32'h1000, 1'b1);
        rdy   = 1'b0;
        req_i = 1'b1;
        pc_i  = 32'h1004;
        #1;
        chk("stall_hit", hit_o, 32'd0);
        step();
        chk("stall_noreq", mem_req_o, 32'd0);
        req_i = 1'b0;
        rdy   = 1'b1;
        probe(32'h1004, 1'b1, "stall_after");
        do_fill(32'h4000, 1'b0);
        probe(32'h4000, 1'b1, "rdy_low_fill");

        // Asynchronous reset between edges during a refill.
        req_i = 1'b1;
        pc_i  = 32'h5000;
        step();
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o);
        step();
        mem_ack_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req_o, 32'd0);
        chk("arst_busy", busy_o, 32'd0);
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        probe(32'h5000, 1'b0, "arst_miss");
        probe(32'h4000, 1'b0, "arst_cleared");

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
